// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
//  Shared definitions for the instruction fetch stage and its neighbours:
//  widths, the reset fetch address, the bubble instruction, the skid-buffer
//  entry layout and small PC / counter arithmetic helpers.
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int PC_W = 16;
  localparam int IW   = 17;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
  localparam logic [IW-1:0]   NOP_INSTR    = 17'h00000;

  // One buffered fetch: the word plus the address following it, which decode
  // uses as JAL link value and branch base.
  typedef struct packed {
    logic [IW-1:0]   instr;
    logic [PC_W-1:0] nxt_pc;
  } fetch_entry_t;

  // Where the word presented to decode comes from this cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_BUF    = 2'd2
  } present_src_e;

  // PC increment; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

  // Saturating 32-bit increment for event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if
//  Fetch -> decode instruction interface.
//   instr        fetched word (NOP_INSTR when nothing valid)
//   instr_vld    instr is a real fetched word
//   nxt_pc       address of instr + 1
//   stall_IM_ID  decode is not accepting; fetch must hold what it presents
//  master = fetch side, slave = decode side.
// ---------------------------------------------------------------------------
interface ifetch_if;
  import ifetch_pkg::*;

  logic [IW-1:0]   instr;
  logic            instr_vld;
  logic [PC_W-1:0] nxt_pc;
  logic            stall_IM_ID;

  modport master (
    output instr,
    output instr_vld,
    output nxt_pc,
    input  stall_IM_ID
  );

  modport slave (
    input  instr,
    input  instr_vld,
    input  nxt_pc,
    output stall_IM_ID
  );

endinterface

// File: rtl/ifetch_buf.sv
// ---------------------------------------------------------------------------
// ifetch_buf
//  Two-entry FIFO holding fetched {instr, nxt_pc} words while decode stalls.
//  Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write wr_entry at the tail
//   pop        drop the head entry
//   clear      discard all entries (wrong-path flush); wins over push/pop
//   wr_entry   entry to write
//   head       oldest entry (meaningful only when cnt != 0)
//   cnt        number of valid entries, 0..2
// ---------------------------------------------------------------------------
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   cnt
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Pointer and occupancy tracking; a flush simply empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt says which slots hold data.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

  // The issue rule in the fetch stage must keep this FIFO from overflowing
  // or underflowing.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && !pop && cnt == 2'd2));
      assert (!(pop && cnt == 2'd0));
    end
  end

endmodule

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
//  Instruction fetch stage. Generates the PC, reads the synchronous
//  instruction memory (data returns the cycle after im_re), and presents
//  {instr, nxt_pc} to decode. A 2-entry skid buffer catches reads that come
//  back while decode stalls, so no in-flight read is ever dropped. A redirect
//  from EX restarts fetch at dst_ID_EX in the same cycle; decode flushes any
//  wrong-path instruction it already holds.
//  Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_if               ifetch_if.master: instr, instr_vld, nxt_pc out,
//                       stall_IM_ID in
//   flow_change_ID_EX   redirect request
//   dst_ID_EX           redirect target
//   im_rdata            IM read data (valid the cycle after im_re)
//   im_re, im_addr      IM read enable / address
//   fetch_cnt           instructions accepted by decode (saturating)
//   redirect_cnt        redirects taken (saturating)
//  Build option: define IFETCH_PERF_CNT_EN to add fetch_cnt/redirect_cnt;
//  without it those ports and counters do not exist.
// ---------------------------------------------------------------------------
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  ifetch_if.master        id_if,
  input  logic            flow_change_ID_EX,
  input  logic [PC_W-1:0] dst_ID_EX,
  input  logic [IW-1:0]   im_rdata,
  output logic            im_re,
  output logic [PC_W-1:0] im_addr
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     redirect_cnt
`endif
);

  logic [PC_W-1:0] pc;
  logic            rd_pend;
  logic [PC_W-1:0] rd_tag;

  logic [1:0]      buf_cnt;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_wr_entry;
  logic            buf_push;
  logic            buf_pop;

  present_src_e    src;
  logic            consume;
  logic [2:0]      owned;
  logic            issue_ok;

  ifetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .clear    (flow_change_ID_EX),
    .wr_entry (buf_wr_entry),
    .head     (buf_head),
    .cnt      (buf_cnt)
  );

  // Presentation mux: buffered words are older than the returning read, so
  // they go first; with an empty buffer the returning read is bypassed
  // straight to decode to avoid a bubble.
  always_comb begin
    src             = SRC_NONE;
    id_if.instr     = NOP_INSTR;
    id_if.instr_vld = 1'b0;
    id_if.nxt_pc    = pc;
    if (buf_cnt != 2'd0) begin
      src             = SRC_BUF;
      id_if.instr     = buf_head.instr;
      id_if.instr_vld = 1'b1;
      id_if.nxt_pc    = buf_head.nxt_pc;
    end else if (rd_pend) begin
      src             = SRC_BYPASS;
      id_if.instr     = im_rdata;
      id_if.instr_vld = 1'b1;
      id_if.nxt_pc    = rd_tag;
    end
  end

  // Handshake and issue control. A redirect suppresses the consume of the
  // word on display (it is wrong-path) and always issues the target read.
  // Otherwise a new read is issued only if, after this cycle's consume, the
  // stage would own at most one word, so buffered plus in-flight never
  // exceeds the two buffer slots.
  always_comb begin
    consume      = id_if.instr_vld && !id_if.stall_IM_ID && !flow_change_ID_EX;
    owned        = 3'(buf_cnt) + 3'(rd_pend) - 3'(consume);
    issue_ok     = (owned <= 3'd1);
    im_re        = !rst && (flow_change_ID_EX || issue_ok);
    im_addr      = flow_change_ID_EX ? dst_ID_EX : pc;
    buf_pop      = (src == SRC_BUF) && consume;
    buf_push     = rd_pend && !flow_change_ID_EX && !((src == SRC_BYPASS) && consume);
    buf_wr_entry = '{instr: im_rdata, nxt_pc: rd_tag};
  end

  // PC and pending-read tracking. rd_tag is the address after the word being
  // read and travels with the read into the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      rd_pend <= 1'b0;
      rd_tag  <= pc_inc(RESET_PC);
    end else if (flow_change_ID_EX) begin
      pc      <= pc_inc(dst_ID_EX);
      rd_pend <= 1'b1;
      rd_tag  <= pc_inc(dst_ID_EX);
    end else begin
      rd_pend <= issue_ok;
      if (issue_ok) begin
        pc     <= pc_inc(pc);
        rd_tag <= pc_inc(pc);
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Saturating event counters for accepted instructions and redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (consume)           fetch_cnt    <= sat_inc(fetch_cnt);
      if (flow_change_ID_EX) redirect_cnt <= sat_inc(redirect_cnt);
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
//  Directed bench for ifetch. The instruction memory model returns its own
//  address as data (IM[n] = n), one cycle after im_re.
// ---------------------------------------------------------------------------
module tb_ifetch;
  import ifetch_pkg::*;

  logic            clk;
  logic            rst;
  logic            flow_change_ID_EX;
  logic [PC_W-1:0] dst_ID_EX;
  logic [IW-1:0]   im_rdata;
  logic            im_re;
  logic [PC_W-1:0] im_addr;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]     fetch_cnt;
  logic [31:0]     redirect_cnt;
`endif

  int total;
  int bad;

  ifetch_if id_if ();

  ifetch dut (
    .clk               (clk),
    .rst               (rst),
    .id_if             (id_if.master),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .im_rdata          (im_rdata),
    .im_re             (im_re),
    .im_addr           (im_addr)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .redirect_cnt      (redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous IM model: IM[n] = n.
  initial im_rdata = '0;
  always @(posedge clk) begin
    if (im_re) im_rdata <= {1'b0, im_addr};
  end

  // One cycle step: drive inputs at the falling edge, let them settle.
  task automatic applyStimulus(input logic stall, input logic fc, input logic [PC_W-1:0] dst);
    @(negedge clk);
    id_if.stall_IM_ID = stall;
    flow_change_ID_EX = fc;
    dst_ID_EX         = dst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    rst               = 1'b1;
    id_if.stall_IM_ID = 1'b0;
    flow_change_ID_EX = 1'b0;
    dst_ID_EX         = '0;

    // Held in reset
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rst_im_re", 32'(im_re), 32'd0);
    checkOutput("rst_vld", 32'(id_if.instr_vld), 32'd0);
    checkOutput("rst_instr", 32'(id_if.instr), 32'(NOP_INSTR));

    // Release: first read issued at RESET_PC, nothing presented yet
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("c1_im_re", 32'(im_re), 32'd1);
    checkOutput("c1_im_addr", 32'(im_addr), 32'h0000);
    checkOutput("c1_vld", 32'(id_if.instr_vld), 32'd0);

    // Streaming: instr 0 valid in cycle 2, one per cycle
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("c2_vld", 32'(id_if.instr_vld), 32'd1);
    checkOutput("c2_instr", 32'(id_if.instr), 32'h0);
    checkOutput("c2_nxt_pc", 32'(id_if.nxt_pc), 32'h1);
    checkOutput("c2_im_addr", 32'(im_addr), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput("stream_instr", 32'(id_if.instr), 32'(i));
      checkOutput("stream_nxt_pc", 32'(id_if.nxt_pc), 32'(i + 1));
    end

    // Stall three cycles on instr 4: buffer fills with 4 and 5, reads stop
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("st1_instr", 32'(id_if.instr), 32'h4);
    checkOutput("st1_im_re", 32'(im_re), 32'd1);
    checkOutput("st1_im_addr", 32'(im_addr), 32'h5);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("st2_instr", 32'(id_if.instr), 32'h4);
    checkOutput("st2_im_re", 32'(im_re), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("st3_instr", 32'(id_if.instr), 32'h4);
    checkOutput("st3_nxt_pc", 32'(id_if.nxt_pc), 32'h5);
    checkOutput("st3_im_re", 32'(im_re), 32'd0);
    checkOutput("st3_buf_cnt", 32'(dut.buf_cnt), 32'd2);

    // Release: 4,5,6,7 back to back
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rel_instr4", 32'(id_if.instr), 32'h4);
    checkOutput("rel_im_re", 32'(im_re), 32'd1);
    checkOutput("rel_im_addr", 32'(im_addr), 32'h6);
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput("rel_instr", 32'(id_if.instr), 32'(i));
      checkOutput("rel_nxt_pc", 32'(id_if.nxt_pc), 32'(i + 1));
    end

    // Redirect to 0x40 while stalled
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("pre_rd_instr", 32'(id_if.instr), 32'h8);
    applyStimulus(1'b1, 1'b1, 16'h0040);
    checkOutput("rd40_im_addr", 32'(im_addr), 32'h40);
    checkOutput("rd40_im_re", 32'(im_re), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rd40_instr", 32'(id_if.instr), 32'h40);
    checkOutput("rd40_nxt_pc", 32'(id_if.nxt_pc), 32'h41);
    checkOutput("rd40_vld", 32'(id_if.instr_vld), 32'd1);
    checkOutput("rd40_buf_cnt", 32'(dut.buf_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rd41_instr", 32'(id_if.instr), 32'h41);

    // Redirect to 0xFFFF: PC wraps to 0
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    checkOutput("rdff_im_addr", 32'(im_addr), 32'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rdff_instr", 32'(id_if.instr), 32'h0FFFF);
    checkOutput("rdff_nxt_pc", 32'(id_if.nxt_pc), 32'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("wrap_instr", 32'(id_if.instr), 32'h0);
    checkOutput("wrap_vld", 32'(id_if.instr_vld), 32'd1);
    checkOutput("wrap_nxt_pc", 32'(id_if.nxt_pc), 32'h0001);

    // Back-to-back redirects: the last one wins
    applyStimulus(1'b0, 1'b1, 16'h0010);
    applyStimulus(1'b0, 1'b1, 16'h0020);
    checkOutput("b2b_im_addr", 32'(im_addr), 32'h20);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("b2b_instr", 32'(id_if.instr), 32'h20);
    checkOutput("b2b_nxt_pc", 32'(id_if.nxt_pc), 32'h21);

    // Fill the buffer, then pulse reset asynchronously mid-cycle
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("full_instr", 32'(id_if.instr), 32'h21);
    checkOutput("full_buf_cnt", 32'(dut.buf_cnt), 32'd2);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_vld", 32'(id_if.instr_vld), 32'd0);
    checkOutput("arst_instr", 32'(id_if.instr), 32'(NOP_INSTR));
    checkOutput("arst_im_re", 32'(im_re), 32'd0);
    checkOutput("arst_buf_cnt", 32'(dut.buf_cnt), 32'd0);
    @(negedge clk);
    rst               = 1'b0;
    id_if.stall_IM_ID = 1'b0;
    #1;
    checkOutput("refetch_im_re", 32'(im_re), 32'd1);
    checkOutput("refetch_im_addr", 32'(im_addr), 32'h0000);
    checkOutput("refetch_vld", 32'(id_if.instr_vld), 32'd0);

    // Ten consumes, then two redirects while stalled
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput("cnt_run_instr", 32'(id_if.instr), 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 16'h0100);
    applyStimulus(1'b1, 1'b1, 16'h0200);
    checkOutput("perf_im_addr", 32'(im_addr), 32'h200);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("perf_instr", 32'(id_if.instr), 32'h200);
    checkOutput("perf_nxt_pc", 32'(id_if.nxt_pc), 32'h201);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("fetch_cnt", fetch_cnt, 32'd10);
    checkOutput("redirect_cnt", redirect_cnt, 32'd2);
`endif

    applyStimulus(1'b0, 1'b0, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
